// File: rtl/smi_stream_ctrl.sv
// Bridges a byte-wide SMI port to N_CH word-wide RX/TX FIFO pairs, with an 8-bit
// register bank on the IOC bus for channel/direction control and error counters.
`timescale 1ns/1ps
module smi_stream_ctrl #(
  parameter int               DATA_W         = 32,
  parameter int               N_CH           = 2,
  parameter bit               SYNC_EN        = 1'b1,
  parameter logic [DATA_W-1:0] UNDERRUN_WORD = '0,
  parameter logic [7:0]       MODULE_VERSION = 8'h02,
  localparam int              BYTES          = DATA_W / 8,
  localparam int              CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_ioc,
  input  logic [7:0]             i_data_in,
  output logic [7:0]             o_data_out,
  input  logic                   i_cs,
  input  logic                   i_fetch_cmd,
  input  logic                   i_load_cmd,
  output logic [N_CH-1:0]        o_rx_fifo_pull,
  input  logic [N_CH*DATA_W-1:0] i_rx_fifo_data,
  input  logic [N_CH-1:0]        i_rx_fifo_empty,
  output logic [N_CH-1:0]        o_tx_fifo_push,
  output logic [DATA_W-1:0]      o_tx_fifo_data,
  input  logic [N_CH-1:0]        i_tx_fifo_full,
  input  logic                   i_smi_soe,
  input  logic                   i_smi_swe,
  input  logic [7:0]             i_smi_data,
  output logic [7:0]             o_smi_data,
  output logic                   o_smi_read_req,
  output logic                   o_smi_write_req,
  output logic [CH_W-1:0]        o_channel,
  output logic                   o_dir,
  output logic                   o_cond_tx
);

  localparam int IDX_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // [0] first sync stage, [1] second sync stage, [2] previous synchronised value
  logic [2:0] soe_sync, swe_sync;
  logic       soe_fall, swe_fall;

  logic [CH_W-1:0]   channel, ch_act;
  logic              dir;
  logic [IDX_W-1:0]  rx_idx, tx_idx;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-9:0] tx_low;
  logic              tx_cond;
  logic [7:0]        cnt_und, cnt_ovf, cnt_sync;

  logic [DATA_W-1:0] rx_head;
  logic              empty_act, full_act;
  logic              rd_en, wr_en;
  logic [7:0]        status;

  assign soe_fall  = soe_sync[2] & ~soe_sync[1];
  assign swe_fall  = swe_sync[2] & ~swe_sync[1];
  assign rx_head   = i_rx_fifo_data[int'(ch_act)*DATA_W +: DATA_W];
  assign empty_act = i_rx_fifo_empty[ch_act];
  assign full_act  = i_tx_fifo_full[ch_act];
  assign rd_en     = i_cs & i_fetch_cmd;
  assign wr_en     = i_cs & i_load_cmd & ~i_fetch_cmd;
  assign status    = {3'b000, tx_idx != '0, rx_idx != '0, dir, full_act, empty_act};

  assign o_smi_read_req  = ~dir & (~empty_act | (rx_idx != '0));
  assign o_smi_write_req = dir & ~full_act;
  assign o_channel       = channel;
  assign o_dir           = dir;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      soe_sync       <= '0;
      swe_sync       <= '0;
      channel        <= '0;
      ch_act         <= '0;
      dir            <= 1'b0;
      rx_idx         <= '0;
      tx_idx         <= '0;
      rx_word        <= '0;
      tx_low         <= '0;
      tx_cond        <= 1'b0;
      cnt_und        <= '0;
      cnt_ovf        <= '0;
      cnt_sync       <= '0;
      o_data_out     <= '0;
      o_smi_data     <= '0;
      o_rx_fifo_pull <= '0;
      o_tx_fifo_push <= '0;
      o_tx_fifo_data <= '0;
      o_cond_tx      <= 1'b0;
    end else begin
      soe_sync       <= {soe_sync[1:0], i_smi_soe};
      swe_sync       <= {swe_sync[1:0], i_smi_swe};
      o_rx_fifo_pull <= '0;
      o_tx_fifo_push <= '0;

      if (rd_en) begin
        case (i_ioc)
          5'd0:    o_data_out <= MODULE_VERSION;
          5'd1:    o_data_out <= status;
          5'd2:    o_data_out <= {{(8-CH_W){1'b0}}, channel};
          5'd3:    o_data_out <= {7'b0, dir};
          5'd4:    o_data_out <= cnt_und;
          5'd5:    o_data_out <= cnt_ovf;
          5'd6:    o_data_out <= cnt_sync;
          default: ;
        endcase
      end

      // The datapath channel only moves between words so a word never straddles FIFOs.
      if (rx_idx == '0 && tx_idx == '0) ch_act <= channel;

      if (wr_en && i_ioc == 5'd2 && int'(i_data_in) < N_CH) channel <= i_data_in[CH_W-1:0];

      if (wr_en && i_ioc == 5'd3 && i_data_in[0] != dir) begin
        dir    <= i_data_in[0];
        rx_idx <= '0;
        tx_idx <= '0;
      end else begin
        if (soe_fall && !dir) begin
          if (rx_idx == '0) begin
            if (!empty_act) begin
              rx_word        <= rx_head;
              o_smi_data     <= rx_head[7:0];
              o_rx_fifo_pull <= N_CH'(1) << ch_act;
            end else begin
              rx_word    <= UNDERRUN_WORD;
              o_smi_data <= UNDERRUN_WORD[7:0];
              cnt_und    <= sat_inc(cnt_und);
            end
          end else begin
            o_smi_data <= rx_word[8*rx_idx +: 8];
          end
          rx_idx <= (rx_idx == LAST_IDX) ? '0 : rx_idx + IDX_ONE;
        end

        if (swe_fall && dir) begin
          if (tx_idx == '0 && SYNC_EN && !i_smi_data[7]) begin
            cnt_sync <= sat_inc(cnt_sync);
          end else if (tx_idx == LAST_IDX) begin
            tx_idx <= '0;
            if (!full_act) begin
              o_tx_fifo_data <= {i_smi_data, tx_low};
              o_tx_fifo_push <= N_CH'(1) << ch_act;
              o_cond_tx      <= tx_cond;
            end else begin
              cnt_ovf <= sat_inc(cnt_ovf);
            end
          end else begin
            tx_low[8*tx_idx +: 8] <= i_smi_data;
            if (tx_idx == '0) tx_cond <= i_smi_data[5];
            tx_idx <= tx_idx + IDX_ONE;
          end
        end
      end

      // Clearing is applied last so it beats any increment in the same cycle.
      if (wr_en && i_ioc == 5'd7) begin
        cnt_und  <= '0;
        cnt_ovf  <= '0;
        cnt_sync <= '0;
      end
    end
  end

endmodule

// File: tb/tb_smi_stream_ctrl.sv
// Randomised bench for smi_stream_ctrl against a byte/word-level model of the bridge.
`timescale 1ns/1ps
module tb_smi_stream_ctrl;

  localparam int DATA_W = 32;
  localparam int N_CH   = 2;
  localparam int CH_W   = 1;
  localparam int BYTES  = DATA_W / 8;
  localparam int SW     = N_CH + 1 + DATA_W;
  localparam logic [DATA_W-1:0] UNDERRUN = '0;

  // ---------------- clock / reset / DUT ----------------
  logic                   i_sys_clk = 1'b0;
  logic                   i_rst;
  logic [4:0]             i_ioc;
  logic [7:0]             i_data_in;
  logic [7:0]             o_data_out;
  logic                   i_cs, i_fetch_cmd, i_load_cmd;
  logic [N_CH-1:0]        o_rx_fifo_pull;
  logic [N_CH*DATA_W-1:0] i_rx_fifo_data;
  logic [N_CH-1:0]        i_rx_fifo_empty;
  logic [N_CH-1:0]        o_tx_fifo_push;
  logic [DATA_W-1:0]      o_tx_fifo_data;
  logic [N_CH-1:0]        i_tx_fifo_full;
  logic                   i_smi_soe, i_smi_swe;
  logic [7:0]             i_smi_data, o_smi_data;
  logic                   o_smi_read_req, o_smi_write_req;
  logic [CH_W-1:0]        o_channel;
  logic                   o_dir, o_cond_tx;

  always #5 i_sys_clk = ~i_sys_clk;

  smi_stream_ctrl #(
    .DATA_W(DATA_W), .N_CH(N_CH), .SYNC_EN(1'b1),
    .UNDERRUN_WORD(UNDERRUN), .MODULE_VERSION(8'h02)
  ) dut (
    .i_sys_clk(i_sys_clk), .i_rst(i_rst), .i_ioc(i_ioc), .i_data_in(i_data_in),
    .o_data_out(o_data_out), .i_cs(i_cs), .i_fetch_cmd(i_fetch_cmd), .i_load_cmd(i_load_cmd),
    .o_rx_fifo_pull(o_rx_fifo_pull), .i_rx_fifo_data(i_rx_fifo_data),
    .i_rx_fifo_empty(i_rx_fifo_empty), .o_tx_fifo_push(o_tx_fifo_push),
    .o_tx_fifo_data(o_tx_fifo_data), .i_tx_fifo_full(i_tx_fifo_full),
    .i_smi_soe(i_smi_soe), .i_smi_swe(i_smi_swe), .i_smi_data(i_smi_data),
    .o_smi_data(o_smi_data), .o_smi_read_req(o_smi_read_req),
    .o_smi_write_req(o_smi_write_req), .o_channel(o_channel), .o_dir(o_dir),
    .o_cond_tx(o_cond_tx)
  );

  // ---------------- scoreboard and model state ----------------
  logic [SW-1:0]     exp_q[$];
  logic [SW-1:0]     act_q[$];
  int                pull_cnt[N_CH];
  int                n_checks = 0;
  int                n_pass   = 0;

  logic [DATA_W-1:0] head[N_CH];
  logic [N_CH-1:0]   empty_v, full_v;
  int                m_und, m_ovf, m_sync, m_channel, m_word_ch;
  bit                m_dir;
  logic [7:0]        m_tx_q[$];
  logic [7:0]        m_smi;

  initial for (int k = 0; k < N_CH; k++) pull_cnt[k] = 0;

  always @(negedge i_sys_clk) begin
    if (o_tx_fifo_push != '0) act_q.push_back({o_tx_fifo_push, o_cond_tx, o_tx_fifo_data});
    for (int k = 0; k < N_CH; k++) if (o_rx_fifo_pull[k]) pull_cnt[k]++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int pulls_total();
    int s = 0;
    for (int k = 0; k < N_CH; k++) s += pull_cnt[k];
    return s;
  endfunction

  task automatic model_reset();
    m_und = 0; m_ovf = 0; m_sync = 0; m_channel = 0; m_word_ch = 0;
    m_dir = 1'b0; m_smi = 8'h00;
    m_tx_q.delete();
  endtask

  // A TX byte at word position 0 must carry the sync bit; BYTES accepted bytes form a word.
  task automatic model_tx_byte(input logic [7:0] b);
    logic [DATA_W-1:0] w;
    logic [N_CH-1:0]   oh;
    if (m_tx_q.size() == 0) m_word_ch = m_channel;
    if (m_tx_q.size() == 0 && !b[7]) begin
      m_sync = sat(m_sync + 1);
    end else begin
      m_tx_q.push_back(b);
      if (m_tx_q.size() == BYTES) begin
        w = '0;
        for (int i = 0; i < BYTES; i++) w[8*i +: 8] = m_tx_q[i];
        if (full_v[m_word_ch]) begin
          m_ovf = sat(m_ovf + 1);
        end else begin
          oh = '0;
          oh[m_word_ch] = 1'b1;
          exp_q.push_back({oh, m_tx_q[0][5], w});
        end
        m_tx_q.delete();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_fifo_inputs();
    for (int k = 0; k < N_CH; k++) i_rx_fifo_data[k*DATA_W +: DATA_W] = head[k];
    i_rx_fifo_empty = empty_v;
    i_tx_fifo_full  = full_v;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge i_sys_clk);
    i_cs = 1'b1; i_load_cmd = 1'b1; i_ioc = a; i_data_in = d;
    @(negedge i_sys_clk);
    i_cs = 1'b0; i_load_cmd = 1'b0;
    if (a == 5'd2 && int'(d) < N_CH) m_channel = int'(d);
    if (a == 5'd3 && d[0] != m_dir) begin
      m_dir = d[0];
      m_tx_q.delete();
    end
    if (a == 5'd7) begin m_und = 0; m_ovf = 0; m_sync = 0; end
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge i_sys_clk);
    i_cs = 1'b1; i_fetch_cmd = 1'b1; i_ioc = a;
    @(negedge i_sys_clk);
    i_cs = 1'b0; i_fetch_cmd = 1'b0;
    d = o_data_out;
  endtask

  task automatic soe_strobe(output logic [7:0] b);
    @(negedge i_sys_clk);
    i_smi_soe = 1'b0;
    repeat (4) @(negedge i_sys_clk);
    b = o_smi_data;
    i_smi_soe = 1'b1;
    repeat (4) @(negedge i_sys_clk);
  endtask

  task automatic swe_byte(input logic [7:0] b);
    @(negedge i_sys_clk);
    i_smi_data = b; i_smi_swe = 1'b0;
    repeat (4) @(negedge i_sys_clk);
    i_smi_swe = 1'b1;
    repeat (4) @(negedge i_sys_clk);
    if (m_dir) model_tx_byte(b);
  endtask

  task automatic sb_drain(input string tag);
    logic [SW-1:0] e;
    repeat (2) @(negedge i_sys_clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_q.size() == 0) check({tag, "_missing"}, '0, e);
      else check(tag, act_q.pop_front(), e);
    end
    check({tag, "_extra"}, act_q.size(), 0);
  endtask

  // One full RX word on channel ch; the FIFO head is w unless emp is set.
  task automatic rx_word(input int ch, input logic [DATA_W-1:0] w, input bit emp);
    logic [7:0]        b, s;
    logic [DATA_W-1:0] ew;
    int                p_ch, p_tot;
    reg_write(5'd2, 8'(ch));
    head[ch] = w; empty_v[ch] = emp;
    apply_fifo_inputs();
    repeat (2) @(negedge i_sys_clk);
    check("rx_read_req", o_smi_read_req, !emp);
    p_ch = pull_cnt[ch]; p_tot = pulls_total();
    ew = emp ? UNDERRUN : w;
    if (emp) m_und = sat(m_und + 1);
    for (int i = 0; i < BYTES; i++) begin
      soe_strobe(b);
      check("rx_byte", b, (ew >> (8*i)) & 'hFF);
      m_smi = b;
      if (i == 1) begin
        reg_read(5'd1, s);
        check("rx_status_mid", s, {3'b000, 1'b0, 1'b1, 1'b0, full_v[ch], emp});
      end
    end
    check("rx_pull_ch", pull_cnt[ch] - p_ch, emp ? 0 : 1);
    check("rx_pull_total", pulls_total() - p_tot, emp ? 0 : 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rd, b;
    int         ch, nb, p_tot;

    i_rst = 1'b1; i_ioc = '0; i_data_in = '0; i_cs = 1'b0;
    i_fetch_cmd = 1'b0; i_load_cmd = 1'b0;
    i_smi_soe = 1'b1; i_smi_swe = 1'b1; i_smi_data = '0;
    for (int k = 0; k < N_CH; k++) head[k] = '0;
    empty_v = '1; full_v = '0;
    apply_fifo_inputs();
    model_reset();
    repeat (3) @(negedge i_sys_clk);
    i_rst = 1'b0;
    @(negedge i_sys_clk);

    check("rst_pull", o_rx_fifo_pull, 0);
    check("rst_push", o_tx_fifo_push, 0);
    check("rst_smi_data", o_smi_data, 0);
    check("rst_dir", o_dir, 0);
    check("rst_channel", o_channel, 0);
    check("rst_cond", o_cond_tx, 0);
    check("rst_read_req", o_smi_read_req, 0);
    reg_read(5'd0, rd); check("version", rd, 8'h02);
    reg_read(5'd1, rd); check("rst_status", rd, 8'h01);

    // RX: directed word, directed underrun, then random words
    rx_word(1, 32'hA1B2C3D4, 1'b0);
    rx_word(0, $urandom, 1'b1);
    reg_read(5'd4, rd); check("underrun_cnt", rd, m_und);
    for (int n = 0; n < 8; n++) rx_word($urandom_range(0, N_CH-1), $urandom, ($urandom_range(0, 3) == 0));
    reg_read(5'd4, rd); check("underrun_cnt_rand", rd, m_und);

    // A write strobe while in RX direction must be ignored
    swe_byte(8'h00);
    reg_read(5'd6, rd); check("swe_in_rx_ignored", rd, m_sync);
    sb_drain("swe_in_rx_push");

    // TX: directed sync error followed by a good word
    reg_write(5'd3, 8'h01);
    reg_write(5'd2, 8'h00);
    check("dir_out", o_dir, m_dir);
    foreach (full_v[k]) full_v[k] = 1'b0;
    apply_fifo_inputs();
    swe_byte(8'h22); swe_byte(8'hA0); swe_byte(8'h11); swe_byte(8'h22); swe_byte(8'h33);
    reg_read(5'd6, rd); check("sync_err_cnt", rd, m_sync);
    sb_drain("tx_directed");
    check("cond_tx", o_cond_tx, 1);

    // A read strobe while in TX direction must be ignored
    p_tot = pulls_total();
    soe_strobe(b);
    check("soe_in_tx_data", b, m_smi);
    check("soe_in_tx_pull", pulls_total() - p_tot, 0);

    // TX: random bytes, channels and full flags, including misaligned bursts
    for (int n = 0; n < 12; n++) begin
      ch = $urandom_range(0, N_CH-1);
      reg_write(5'd2, 8'(ch));
      for (int k = 0; k < N_CH; k++) full_v[k] = ($urandom_range(0, 3) == 0);
      apply_fifo_inputs();
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) != 0) b[7] = 1'b1;
        swe_byte(b);
      end
      sb_drain("tx_rand");
      check("write_req", o_smi_write_req,
            m_dir & !full_v[(m_tx_q.size() == 0) ? m_channel : m_word_ch]);
    end
    reg_read(5'd5, rd); check("ovf_cnt_rand", rd, m_ovf);
    reg_read(5'd6, rd); check("sync_cnt_rand", rd, m_sync);

    // TX overflow saturation, then counter clear
    reg_write(5'd3, 8'h00); reg_write(5'd3, 8'h01);
    reg_write(5'd2, 8'h00);
    full_v = '0; full_v[0] = 1'b1;
    apply_fifo_inputs();
    for (int n = 0; n < 300; n++) begin
      swe_byte(8'h80 | 8'($urandom_range(0, 127)));
      for (int i = 1; i < BYTES; i++) swe_byte(8'($urandom));
    end
    reg_read(5'd5, rd); check("ovf_saturated", rd, m_ovf);
    sb_drain("ovf_no_push");
    reg_write(5'd7, 8'h00);
    reg_read(5'd4, rd); check("clr_underrun", rd, m_und);
    reg_read(5'd5, rd); check("clr_overflow", rd, m_ovf);
    reg_read(5'd6, rd); check("clr_sync", rd, m_sync);

    // Channel change mid-word takes effect only at the next word
    full_v = '0;
    apply_fifo_inputs();
    swe_byte(8'hA0); swe_byte(8'h11);
    reg_write(5'd2, 8'h01);
    swe_byte(8'h22); swe_byte(8'h33);
    sb_drain("tx_mid_ch_change");
    check("channel_out", o_channel, m_channel);

    // Reset in the middle of a word discards it
    swe_byte(8'hC5); swe_byte(8'h01);
    @(negedge i_sys_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_sys_clk);
    i_rst = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge i_sys_clk);
    sb_drain("rst_mid_word");
    reg_read(5'd1, rd); check("rst_mid_status", rd, {6'b0, full_v[0], empty_v[0]});
    check("rst_mid_dir", o_dir, m_dir);
    check("rst_mid_channel", o_channel, m_channel);
    check("rst_mid_cond", o_cond_tx, 0);
    check("rst_mid_smi_data", o_smi_data, m_smi);
    check("rst_mid_tx_data", o_tx_fifo_data, 0);

    reg_write(5'd3, 8'h01);
    swe_byte(8'h80); swe_byte(8'h01); swe_byte(8'h02); swe_byte(8'h03);
    sb_drain("tx_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/smi_stream_ctrl.md
Name: smi_stream_ctrl

Overview:
- Parametrised SMI-to-FIFO bridge, successor to the single-channel byte-pair SMI controller.
- Fully synchronous to i_sys_clk: SMI strobes are synchronised and edge-detected, never used as clocks.
- Supports N_CH channels, configurable sample width, TX frame-sync checking and saturating RX-underrun, TX-overflow and sync-error counters, all readable over the IOC bus.

Parameters:
- DATA_W, 32, FIFO word width in bits; multiple of 8, 16..64; BYTES = DATA_W/8.
- N_CH, 2, channel count, 1..4; CH_W = max(1, clog2(N_CH)).
- SYNC_EN, 1, when 1, byte 0 of every TX word must have bit[7]=1.
- UNDERRUN_WORD, 0, word sent on SMI when the selected RX FIFO is empty at a word boundary.
- MODULE_VERSION, 8'h02, value returned at ioc 0.

Ports:
- i_sys_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_ioc  in  5  register address
- i_data_in  in  8  register write data
- o_data_out  out  8  register read data
- i_cs  in  1  block select
- i_fetch_cmd  in  1  register read strobe
- i_load_cmd  in  1  register write strobe
- o_rx_fifo_pull  out  N_CH  one-hot pull pulse, one per channel
- i_rx_fifo_data  in  N_CH*DATA_W  RX FIFO heads; channel k at [k*DATA_W +: DATA_W]
- i_rx_fifo_empty  in  N_CH  RX FIFO empty flags
- o_tx_fifo_push  out  N_CH  one-hot push pulse
- o_tx_fifo_data  out  DATA_W  TX word, shared by all channels
- i_tx_fifo_full  in  N_CH  TX FIFO full flags
- i_smi_soe  in  1  SMI read strobe (asynchronous)
- i_smi_swe  in  1  SMI write strobe (asynchronous)
- i_smi_data  in  8  SMI write data
- o_smi_data  out  8  SMI read data
- o_smi_read_req  out  1  read request to host
- o_smi_write_req  out  1  write request to host
- o_channel  out  CH_W  active channel
- o_dir  out  1  direction: 0 = RX (FPGA to host), 1 = TX
- o_cond_tx  out  1  conditional-TX flag from the last complete TX word

Behaviour:
- Reset: all outputs 0 (o_smi_data=0, pulls/pushes=0); rx_idx, tx_idx, counters, channel, dir = 0. A partial word is discarded; no push.
- Strobe sync: 2-FF synchroniser on i_smi_soe and i_smi_swe, plus a previous-value register. A fall (prev=1, cur=0) gives a 1-cycle event 3 cycles after the pin edge. Host guarantees strobe low and high time each >= 3 sys clocks.
- Register read: on i_cs & i_fetch_cmd, o_data_out is registered on the next edge.
  - ioc 0: MODULE_VERSION.
  - ioc 1: {3'b0, tx_idx!=0, rx_idx!=0, dir, full[ch], empty[ch]}.
  - ioc 2: channel.
  - ioc 3: dir.
  - ioc 4: rx_underrun_cnt.
  - ioc 5: tx_overflow_cnt.
  - ioc 6: sync_err_cnt.
  - Other addresses: o_data_out holds its value.
- Register write: on i_cs & i_load_cmd.
  - ioc 2: channel <= i_data_in[CH_W-1:0]; the write is ignored if the value is >= N_CH.
  - ioc 3: dir <= i_data_in[0].
  - ioc 7: clear all counters; clear wins over a same-cycle increment.
  - fetch_cmd has priority over load_cmd.
- Active channel: ch_act is latched from channel only when rx_idx==0 and tx_idx==0. A mid-word channel change takes effect at the next word boundary.
- Counters: 8-bit, saturate at 8'hFF.
- RX path (SOE events, only when dir=0):
  - rx_idx==0 and !empty[ch_act]: latch word into the shift register, o_smi_data <= word[7:0], pulse o_rx_fifo_pull[ch_act] for 1 cycle.
  - rx_idx==0 and empty: latch UNDERRUN_WORD, output its byte 0, rx_underrun_cnt++, no pull.
  - rx_idx>0: o_smi_data <= byte rx_idx (little-endian).
  - rx_idx wraps at BYTES-1 -> 0.
- TX path (SWE events, only when dir=1):
  - tx_idx==0, SYNC_EN=1, byte[7]=0: discard byte, sync_err_cnt++, stay at idx 0.
  - Otherwise store byte at [8*tx_idx +: 8]. On byte 0, capture cond = byte[5].
  - On byte BYTES-1 with !full[ch_act]: o_tx_fifo_data <= assembled word, 1-cycle o_tx_fifo_push[ch_act] pulse in the same cycle, o_cond_tx <= cond.
  - On byte BYTES-1 with full[ch_act]: drop word, tx_overflow_cnt++.
  - tx_idx then returns to 0.
- Strobes arriving in the wrong direction are ignored. A dir change resets both rx_idx and tx_idx to 0.
- Requests:
  - o_smi_read_req = !dir & (!empty[ch_act] | rx_idx!=0).
  - o_smi_write_req = dir & !full[ch_act].
- o_channel = channel register; o_dir = dir.

Test Plan:
- Reset, then read ioc 0 and ioc 1 with all FIFOs empty -> 8'h02; status 8'h01; all pull/push outputs 0.
- dir=0, ch=1, RX FIFO 1 head 32'hA1B2C3D4, 4 SOE falls -> bytes D4,C3,B2,A1; exactly one pull[1] pulse, at the first fall.
- dir=0, selected FIFO empty, 4 SOE falls with UNDERRUN_WORD=0 -> bytes 00×4; ioc 4 reads 1; no pull.
- dir=1, SWE bytes 0x22 then 0xA0,0x11,0x22,0x33 -> ioc 6 = 1; push[0] with data 32'h332211A0; o_cond_tx=1.
- dir=1, full[0]=1, 300 complete words -> ioc 5 = 8'hFF (saturated); no push. Write ioc 7 -> reads 0.
- Write ch=1 after 2 of 4 TX bytes; assert i_rst mid-word -> the remaining bytes still go to ch 0; after reset tx_idx=0 and no push issued.
